// File: rtl/write_merge_fifo_pkg.sv
// ============================================================================
// Module : cave_mem_pkg
// Brief  : Shared request type and width helpers for the write-merge FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cave_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 17;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MASK_WIDTH = DEF_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      wr;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] din;
        logic [DEF_MASK_WIDTH-1:0] mask;
    } req_t;

    function automatic int mask_width(input int dw);
        return dw / 8;
    endfunction

    // One extra bit so a full FIFO (count == DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/write_merge_fifo_if.sv
// ============================================================================
// Module : write_merge_fifo_if
// Brief  : Enqueue/dequeue handshake bundle for the write-merge FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface write_merge_fifo_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  io_enq_ready;
    logic                  io_enq_valid;
    logic                  io_enq_bits_wr;
    logic [ADDR_WIDTH-1:0] io_enq_bits_addr;
    logic [DATA_WIDTH-1:0] io_enq_bits_din;
    logic [MASK_WIDTH-1:0] io_enq_bits_mask;

    logic                  io_deq_ready;
    logic                  io_deq_valid;
    logic                  io_deq_bits_wr;
    logic [ADDR_WIDTH-1:0] io_deq_bits_addr;
    logic [DATA_WIDTH-1:0] io_deq_bits_din;
    logic [MASK_WIDTH-1:0] io_deq_bits_mask;

    modport slave (
        output io_enq_ready,
        input  io_enq_valid, io_enq_bits_wr, io_enq_bits_addr,
        input  io_enq_bits_din, io_enq_bits_mask,
        input  io_deq_ready,
        output io_deq_valid, io_deq_bits_wr, io_deq_bits_addr,
        output io_deq_bits_din, io_deq_bits_mask
    );

    modport master (
        input  io_enq_ready,
        output io_enq_valid, io_enq_bits_wr, io_enq_bits_addr,
        output io_enq_bits_din, io_enq_bits_mask,
        output io_deq_ready,
        input  io_deq_valid, io_deq_bits_wr, io_deq_bits_addr,
        input  io_deq_bits_din, io_deq_bits_mask
    );

endinterface

`default_nettype wire

// File: rtl/write_merge_fifo_ram.sv
// ============================================================================
// Module : write_merge_fifo_ram
// Brief  : Entry register file, byte-enabled write, async head and tail reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module write_merge_fifo_ram
    import cave_mem_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
) (
    input  wire logic                            clk,
    input  wire logic                            i_we,
    input  wire logic [$clog2(DEPTH)-1:0]        i_waddr,
    input  wire logic                            i_wr,
    input  wire logic [ADDR_WIDTH-1:0]           i_addr,
    input  wire logic [DATA_WIDTH-1:0]           i_din,
    input  wire logic [mask_width(DATA_WIDTH)-1:0] i_mask,
    input  wire logic [mask_width(DATA_WIDTH)-1:0] i_din_be,
    input  wire logic [$clog2(DEPTH)-1:0]        i_head_ptr,
    output logic                                 o_head_wr,
    output logic [ADDR_WIDTH-1:0]                o_head_addr,
    output logic [DATA_WIDTH-1:0]                o_head_din,
    output logic [mask_width(DATA_WIDTH)-1:0]    o_head_mask,
    input  wire logic [$clog2(DEPTH)-1:0]        i_tail_ptr,
    output logic                                 o_tail_wr,
    output logic [ADDR_WIDTH-1:0]                o_tail_addr,
    output logic [mask_width(DATA_WIDTH)-1:0]    o_tail_mask
);
    localparam int MW = mask_width(DATA_WIDTH);

    logic                  r_wr   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_din  [DEPTH];
    logic [MW-1:0]         r_mask [DEPTH];

    // Storage is not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_wr[i_waddr]   <= i_wr;
            r_addr[i_waddr] <= i_addr;
            r_mask[i_waddr] <= i_mask;
            for (int b = 0; b < MW; b++) begin
                if (i_din_be[b]) begin
                    r_din[i_waddr][8*b +: 8] <= i_din[8*b +: 8];
                end
            end
        end
    end

    assign o_head_wr   = r_wr[i_head_ptr];
    assign o_head_addr = r_addr[i_head_ptr];
    assign o_head_din  = r_din[i_head_ptr];
    assign o_head_mask = r_mask[i_head_ptr];

    assign o_tail_wr   = r_wr[i_tail_ptr];
    assign o_tail_addr = r_addr[i_tail_ptr];
    assign o_tail_mask = r_mask[i_tail_ptr];

endmodule

`default_nettype wire

// File: rtl/write_merge_fifo.sv
// ============================================================================
// Module : write_merge_fifo
// Brief  : FWFT request FIFO that folds back-to-back same-address writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module write_merge_fifo
    import cave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12,
    parameter int MERGE_EN    = 1
) (
    input  wire logic                        clock,
    input  wire logic                        reset_n,
    write_merge_fifo_if.slave                bus,
    output logic [cnt_width(DEPTH)-1:0]      io_count,
    output logic                             io_almostFull
);
    localparam int MW = mask_width(DATA_WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    logic          w_enq_fire;
    logic          w_deq_fire;
    logic          w_merge;
    logic          w_alloc;
    logic [PW-1:0] w_tail_ptr;

    logic                  w_tail_wr;
    logic [ADDR_WIDTH-1:0] w_tail_addr;
    logic [MW-1:0]         w_tail_mask;

    logic [PW-1:0] w_waddr;
    logic [MW-1:0] w_wmask;
    logic [MW-1:0] w_wbe;

    assign bus.io_enq_ready = (r_count != C_DEPTH);
    assign bus.io_deq_valid = (r_count != '0);
    assign io_count         = r_count;
    assign io_almostFull    = (r_count >= C_AFULL);

    assign w_enq_fire = bus.io_enq_valid & bus.io_enq_ready;
    assign w_deq_fire = bus.io_deq_valid & bus.io_deq_ready;
    assign w_tail_ptr = r_wptr - PW'(1);

    generate
        if (MERGE_EN != 0) begin : g_merge
            // A lone entry being dequeued this cycle must not absorb the write.
            assign w_merge = w_enq_fire & (r_count != '0)
                           & w_tail_wr & bus.io_enq_bits_wr
                           & (w_tail_addr == bus.io_enq_bits_addr)
                           & ~((r_count == C_ONE) & w_deq_fire);
        end else begin : g_no_merge
            assign w_merge = 1'b0;
        end
    endgenerate

    assign w_alloc = w_enq_fire & ~w_merge;
    assign w_waddr = w_merge ? w_tail_ptr : r_wptr;
    assign w_wmask = w_merge ? (w_tail_mask | bus.io_enq_bits_mask) : bus.io_enq_bits_mask;
    assign w_wbe   = w_merge ? bus.io_enq_bits_mask : {MW{1'b1}};

    always_comb begin
        w_count_nxt = r_count;
        case ({w_alloc, w_deq_fire})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc)    r_wptr <= r_wptr + PW'(1);
            if (w_deq_fire) r_rptr <= r_rptr + PW'(1);
            r_count <= w_count_nxt;
        end
    end

    write_merge_fifo_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk         (clock),
        .i_we        (w_enq_fire),
        .i_waddr     (w_waddr),
        .i_wr        (bus.io_enq_bits_wr),
        .i_addr      (bus.io_enq_bits_addr),
        .i_din       (bus.io_enq_bits_din),
        .i_mask      (w_wmask),
        .i_din_be    (w_wbe),
        .i_head_ptr  (r_rptr),
        .o_head_wr   (bus.io_deq_bits_wr),
        .o_head_addr (bus.io_deq_bits_addr),
        .o_head_din  (bus.io_deq_bits_din),
        .o_head_mask (bus.io_deq_bits_mask),
        .i_tail_ptr  (w_tail_ptr),
        .o_tail_wr   (w_tail_wr),
        .o_tail_addr (w_tail_addr),
        .o_tail_mask (w_tail_mask)
    );

endmodule

`default_nettype wire
